toilet_input_ctrl: RTL and testbench

//  Front-end stage feeding the controller. Synchronises and debounces the raw seat sensor and user buttons.

---
 rtl/toilet_input_ctrl.sv | 160 ++++++++++++++++
 tb/tb_toilet_input_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/toilet_input_ctrl.sv
// Input front-end: 2-FF sync + debounce of seat sensor and buttons, seat occupancy FSM, and
// registered reg_* command levels. Optional macro STUCK_SENSOR_EN adds the occupancy limit.
module toilet_input_ctrl #(
    parameter int unsigned DEB_CYC     = 4,
    parameter int unsigned ARRIVE_CYC  = 8,
    parameter int unsigned LEAVE_CYC   = 16,
    parameter int unsigned MAX_OCC_CYC = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic seat_sensor_i,
    input  logic btn_spray_i,
    input  logic btn_mode_i,
    input  logic btn_deur_i,
    input  logic cfg_auto_dis_i,
    input  logic count_spray_done,
    output logic reg_user_en,
    output logic reg_spray_en,
    output logic reg_spray_mode,
    output logic reg_auto_dis_en,
    output logic reg_de_ur,
    output logic sensor_fault
);

    localparam int unsigned NIN = 4;
    localparam int unsigned DW  = $clog2(DEB_CYC + 1);

    typedef enum logic [1:0] {StIdle, StArriving, StOccupied, StLeaving} state_t;

    // Bit order: 0 seat, 1 spray, 2 mode, 3 deur
    logic [NIN-1:0] raw, sync1_q, sync2_q, deb_q, deb_prev_q, press;
    logic [DW-1:0]  deb_cnt_q [NIN];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q;
    logic             timer_run, enter_idle, dseat, hold_idle;

    assign raw   = {btn_deur_i, btn_mode_i, btn_spray_i, seat_sensor_i};
    assign press = deb_q & ~deb_prev_q;
    assign dseat = deb_q[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < NIN; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < NIN; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DW'(DEB_CYC - 1)) begin
                    deb_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef STUCK_SENSOR_EN
    logic force_rel, fault_q, hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
            hold_q  <= 1'b0;
        end else if (force_rel) begin
            fault_q <= 1'b1;
            hold_q  <= 1'b1;
        end else if (!dseat) begin
            fault_q <= 1'b0;
            hold_q  <= 1'b0;
        end
    end

    assign hold_idle    = hold_q;
    assign sensor_fault = fault_q;
`else
    assign hold_idle    = 1'b0;
    assign sensor_fault = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        timer_run = 1'b0;
`ifdef STUCK_SENSOR_EN
        force_rel = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (dseat && !hold_idle) state_d = StArriving;
            end
            StArriving: begin
                timer_run = 1'b1;
                if (!dseat) state_d = StIdle;
                else if (timer_q == CNT_W'(ARRIVE_CYC - 1)) state_d = StOccupied;
            end
            StOccupied: begin
`ifdef STUCK_SENSOR_EN
                timer_run = 1'b1;
                if (!dseat) begin
                    state_d = StLeaving;
                end else if (timer_q == CNT_W'(MAX_OCC_CYC - 1)) begin
                    state_d   = StIdle;
                    force_rel = 1'b1;
                end
`else
                if (!dseat) state_d = StLeaving;
`endif
            end
            StLeaving: begin
                timer_run = 1'b1;
                if (dseat) state_d = StOccupied;
                else if (timer_q == CNT_W'(LEAVE_CYC - 1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign enter_idle = (state_d == StIdle) && (state_q != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            timer_q         <= '0;
            reg_user_en     <= 1'b0;
            reg_spray_en    <= 1'b0;
            reg_spray_mode  <= 1'b0;
            reg_auto_dis_en <= 1'b0;
            reg_de_ur       <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) || !timer_run) timer_q <= '0;
            else timer_q <= timer_q + 1'b1;

            reg_user_en <= (state_d == StOccupied) || (state_d == StLeaving);

            // A spray-done pulse overrides a coincident press
            if (enter_idle || count_spray_done) reg_spray_en <= 1'b0;
            else if (press[1] && reg_user_en) reg_spray_en <= ~reg_spray_en;

            if (enter_idle) reg_spray_mode <= 1'b0;
            else if (press[2] && reg_user_en && !reg_spray_en) reg_spray_mode <= ~reg_spray_mode;

            if (state_q == StIdle) reg_auto_dis_en <= cfg_auto_dis_i;

            // Deodorise request survives departure; only a new arrival clears it
            if ((state_q == StIdle) && (state_d == StArriving)) reg_de_ur <= 1'b0;
            else if (press[3] && reg_user_en) reg_de_ur <= 1'b1;
        end
    end

endmodule

// File: tb/tb_toilet_input_ctrl.sv
// Directed bench for toilet_input_ctrl (MAX_OCC_CYC=50); STUCK_SENSOR_EN selects the limit checks.
module tb_toilet_input_ctrl;

`ifdef STUCK_SENSOR_EN
    localparam bit Stuck = 1'b1;
`else
    localparam bit Stuck = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       seat;
    logic [2:0] btn; // 0 spray, 1 mode, 2 deur
    logic       cfg_auto;
    logic       done;
    logic       user_en, spray_en, spray_mode, auto_dis_en, de_ur, fault;

    int n_tests = 0;
    int n_fail  = 0;

    toilet_input_ctrl #(
        .DEB_CYC     (4),
        .ARRIVE_CYC  (8),
        .LEAVE_CYC   (16),
        .MAX_OCC_CYC (50),
        .CNT_W       (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .seat_sensor_i    (seat),
        .btn_spray_i      (btn[0]),
        .btn_mode_i       (btn[1]),
        .btn_deur_i       (btn[2]),
        .cfg_auto_dis_i   (cfg_auto),
        .count_spray_done (done),
        .reg_user_en      (user_en),
        .reg_spray_en     (spray_en),
        .reg_spray_mode   (spray_mode),
        .reg_auto_dis_en  (auto_dis_en),
        .reg_de_ur        (de_ur),
        .sensor_fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        tick(8);
        btn[idx] = 1'b0;
        tick(8);
    endtask

    function automatic logic [7:0] outs();
        return {2'b00, fault, de_ur, auto_dis_en, spray_mode, spray_en, user_en};
    endfunction

    initial begin
        logic seen;
        reset    = 1'b1;
        seat     = 1'b0;
        btn      = 3'b000;
        cfg_auto = 1'b0;
        done     = 1'b0;
        #2;
        chk("reset_outs", outs(), 8'h00);
        tick(3);
        reset = 1'b0;
        tick(2);
        chk("post_reset_outs", outs(), 8'h00);

        // Short seat pulse then sub-debounce bounces: never occupied
        seen = 1'b0;
        seat = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(1); seen |= user_en; end
        seat = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(1); seen |= user_en; end
        for (int b = 0; b < 4; b++) begin
            seat = 1'b1;
            for (int i = 0; i < 3; i++) begin tick(1); seen |= user_en; end
            seat = 1'b0;
            for (int i = 0; i < 3; i++) begin tick(1); seen |= user_en; end
        end
        for (int i = 0; i < 20; i++) begin tick(1); seen |= user_en; end
        chk("bounce_no_user", seen, 1'b0);

        cfg_auto = 1'b1;
        tick(1);
        chk("auto_load_idle", auto_dis_en, 1'b1);

        // Arrival: user_en exactly 15 edges after the seat rise, nothing else moves before
        seen = 1'b0;
        seat = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            seen |= user_en | spray_en | spray_mode | de_ur | fault;
        end
        chk("arrive_no_glitch", seen, 1'b0);
        tick(1);
        chk("arrive_15", user_en, 1'b1);
        cfg_auto = 1'b0;
        tick(3);
        chk("auto_hold_occ", auto_dis_en, 1'b1);

        press(0);
        chk("spray_on", spray_en, 1'b1);
        press(1);
        chk("mode_locked", spray_mode, 1'b0);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        chk("spray_done_clr", spray_en, 1'b0);
        press(1);
        chk("mode_toggle", spray_mode, 1'b1);

        // Press pulse lands on edge +7 after the raw rise; done coincides
        btn[0] = 1'b1;
        tick(6);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        chk("done_beats_press", spray_en, 1'b0);
        btn[0] = 1'b0;
        tick(8);
        chk("spray_still_off", spray_en, 1'b0);

        press(0);
        chk("spray_on_again", spray_en, 1'b1);
        press(2);
        chk("deur_set", de_ur, 1'b1);

        // 10-cycle seat gap: LEAVING then back to OCCUPIED
        seen = 1'b1;
        seat = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(1); seen &= user_en; end
        seat = 1'b1;
        for (int i = 0; i < 30; i++) begin tick(1); seen &= user_en; end
        chk("gap_user_held", seen, 1'b1);
        chk("gap_spray_held", spray_en, 1'b1);

        // Departure: user_en drops exactly 23 edges after seat fall
        seat = 1'b0;
        tick(22);
        chk("leave_22", user_en, 1'b1);
        tick(1);
        chk("leave_23", user_en, 1'b0);
        chk("leave_spray_clr", spray_en, 1'b0);
        chk("leave_mode_clr", spray_mode, 1'b0);
        tick(20);
        chk("deur_held_idle", de_ur, 1'b1);
        chk("auto_reload_idle", auto_dis_en, 1'b0);
        press(0);
        chk("idle_press_ignored", spray_en, 1'b0);

        // Re-arrival clears de_ur on the IDLE->ARRIVING edge (+7)
        seat = 1'b1;
        tick(6);
        chk("deur_before_arr", de_ur, 1'b1);
        tick(1);
        chk("deur_cleared_arr", de_ur, 1'b0);
        tick(8);
        chk("rearrive_15", user_en, 1'b1);

        // Occupancy limit: 50 edges after OCCUPIED entry
        tick(49);
        chk("occ_49", user_en, 1'b1);
        tick(1);
        chk("occ_50_user", user_en, !Stuck);
        chk("occ_50_fault", fault, Stuck);
        tick(30);
        chk("occ_hold_user", user_en, !Stuck);
        seat = 1'b0;
        tick(30);
        chk("fault_cleared", fault, 1'b0);
        chk("released_user", user_en, 1'b0);

        cfg_auto = 1'b1;
        tick(1);
        seat = 1'b1;
        tick(15);
        chk("arrive_after_fault", user_en, 1'b1);
        press(0);
        chk("spray_pre_reset", spray_en, 1'b1);
        chk("auto_pre_reset", auto_dis_en, 1'b1);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outs", outs(), 8'h00);
        tick(2);
        chk("reset_held_outs", outs(), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
